axis_ingress_pkt_fifo: RTL and testbench

Per-port store-and-forward packet FIFO with drop-on-overflow. One instance per ingress port, placed directly upstream of `axi_stream_queue_manager`. It accepts AXI-Stream beats at line rate and never back-pressures the source. A packet becomes visible on the master side only after its `tlast` beat has been stored. Packets that do not fit in the remaining space are discarded whole and counted.

---
 rtl/axis_pkg.sv | 23 ++
 rtl/axis_sdp_ram.sv | 30 +++
 rtl/axis_ingress_pkt_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_axis_ingress_pkt_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream ingress packet FIFO.
package axis_pkg;

  localparam int AXIS_DATA_SIZE = 32;
  localparam int DROP_CNT_W = 32;

  typedef struct packed {
    logic                        tlast;
    logic [AXIS_DATA_SIZE/8-1:0] tkeep;
    logic [AXIS_DATA_SIZE-1:0]   tdata;
  } axis_word_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_e;

  // Stored word width for a given tdata width: tlast + tkeep + tdata.
  function automatic int word_bits(input int dsize);
    return dsize + dsize / 8 + 1;
  endfunction

endpackage

// File: rtl/axis_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module axis_sdp_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 37,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_ingress_pkt_fifo.sv
// Store-and-forward ingress packet FIFO; packets that do not fit are
// dropped whole and counted. Never back-pressures the source.
module axis_ingress_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_SIZE-1:0]   s_tdata,
  input  logic [DATA_SIZE/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_SIZE-1:0]   m_tdata,
  output logic [DATA_SIZE/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [ADDR_W:0]        pkt_count,
  output logic [ADDR_W:0]        fill_level,
  output logic [DROP_CNT_W-1:0]  drop_pkt_cnt
);

  localparam int KEEP_W = DATA_SIZE / 8;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int WORD_W = word_bits(DATA_SIZE);

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_SIZE-1:0] tdata;
  } word_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  wr_state_e state_q, state_d;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t commit_ptr_q, commit_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t fetch_ptr_q, fetch_ptr_d;
  ptr_t pkt_count_q, pkt_count_d;
  ptr_t fill_q, fill_d;

  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic  ram_vld_q, ram_vld_d;
  logic  m_vld_q, m_vld_d;
  word_t m_word_q, m_word_d;
  word_t s_word;
  logic [WORD_W-1:0] ram_rdata;
  word_t ram_word;

  logic beat;
  logic full;
  logic ram_we;
  logic commit;
  logic drop_evt;
  logic out_rdy;
  logic hs;
  logic hs_last;
  logic rd_issue;

  assign s_tready = !rst;
  assign beat     = s_tvalid && s_tready;
  assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign s_word   = '{tlast: s_tlast, tkeep: s_tkeep, tdata: s_tdata};
  assign ram_word = word_t'(ram_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      pkt_count_q  <= '0;
      fill_q       <= '0;
      drop_q       <= '0;
      ram_vld_q    <= 1'b0;
      m_vld_q      <= 1'b0;
      m_word_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      pkt_count_q  <= pkt_count_d;
      fill_q       <= fill_d;
      drop_q       <= drop_d;
      ram_vld_q    <= ram_vld_d;
      m_vld_q      <= m_vld_d;
      m_word_q     <= m_word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCEPT: begin
        if (beat && full && !s_tlast) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (beat && s_tlast) begin
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    ram_we       = 1'b0;
    commit       = 1'b0;
    drop_evt     = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    if (beat) begin
      unique case (state_q)
        ACCEPT: begin
          if (!full) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (s_tlast) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + ONE;
            end
          end else begin
            // Rewind over the partial packet; its space is reclaimed.
            wr_ptr_d = commit_ptr_q;
            drop_evt = s_tlast;
          end
        end
        DROP: begin
          drop_evt = s_tlast;
        end
        default: ;
      endcase
    end
  end

  // Read side: RAM read stage feeding an output register.
  // fetch_ptr runs ahead of rd_ptr by at most the two staged beats.
  always_comb begin
    out_rdy     = !m_vld_q || m_tready;
    hs          = m_vld_q && m_tready;
    hs_last     = hs && m_word_q.tlast;
    rd_issue    = (fetch_ptr_q != commit_ptr_q) && (!ram_vld_q || out_rdy);
    fetch_ptr_d = rd_issue ? fetch_ptr_q + ONE : fetch_ptr_q;
    ram_vld_d   = rd_issue || (ram_vld_q && !out_rdy);
    m_vld_d     = out_rdy ? ram_vld_q : m_vld_q;
    m_word_d    = (out_rdy && ram_vld_q) ? ram_word : m_word_q;
    rd_ptr_d    = hs ? rd_ptr_q + ONE : rd_ptr_q;
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (commit && !hs_last) begin
      pkt_count_d = pkt_count_q + ONE;
    end else if (!commit && hs_last) begin
      pkt_count_d = pkt_count_q - ONE;
    end
    fill_d = commit_ptr_d - rd_ptr_d;
    drop_d = drop_q;
    if (drop_evt && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  axis_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(s_word),
    .re   (rd_issue),
    .raddr(fetch_ptr_q[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  assign m_tvalid     = m_vld_q;
  assign m_tdata      = m_word_q.tdata;
  assign m_tkeep      = m_word_q.tkeep;
  assign m_tlast      = m_word_q.tlast;
  assign pkt_count    = pkt_count_q;
  assign fill_level   = fill_q;
  assign drop_pkt_cnt = drop_q;

endmodule

// File: tb/tb_axis_ingress_pkt_fifo.sv
// Scoreboard bench for axis_ingress_pkt_fifo (DEPTH=16, 32-bit data).
module tb_axis_ingress_pkt_fifo;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef logic [DW+KW:0] word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [AW:0]   pkt_count;
  logic [AW:0]   fill_level;
  logic [31:0]   drop_pkt_cnt;

  axis_ingress_pkt_fifo #(
    .DATA_SIZE(DW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .pkt_count   (pkt_count),
    .fill_level  (fill_level),
    .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  word_t cur[$];
  int    vec = 0;
  int    errs = 0;
  int    commit_beats = 0;
  int    commit_pkts = 0;
  int    drops = 0;
  bit    in_drop = 0;
  int    hs_cnt = 0;
  int    hs_last_cnt = 0;
  bit    pend = 0;
  bit    pend_last = 0;
  int    mode = 0;
  bit    prev_stall = 0;
  word_t prev_word = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor: picks m_tready for the coming edge, then pops
  // and compares the beat that edge will transfer.
  always @(negedge clk) begin : mon
    word_t w;
    word_t e;
    bit    h;
    case (mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(1, 0) == 1);
    endcase
    w = {m_tlast, m_tkeep, m_tdata};
    if (prev_stall && !rst) begin
      chk("stall_valid", 64'(m_tvalid), 64'(1));
      chk("stall_word", 64'(w), 64'(prev_word));
    end
    h = m_tvalid && m_tready && !rst;
    pend = h;
    pend_last = h && m_tlast;
    if (h) begin
      hs_cnt++;
      if (m_tlast) hs_last_cnt++;
      if (exp_q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_beat: got %0h expected none", w);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'(w), 64'(e));
      end
    end
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_word = w;
  end

  task automatic chk_status();
    chk("s_tready", 64'(s_tready), 64'(1));
    chk("pkt_count", 64'(pkt_count),
        64'(commit_pkts - (hs_last_cnt - int'(pend_last))));
    chk("fill_level", 64'(fill_level),
        64'(commit_beats - (hs_cnt - int'(pend))));
    chk("drop_cnt", 64'(drop_pkt_cnt), 64'(drops));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (!rst) chk_status();
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) step();
  endtask

  // Reference: a packet is kept only if stored beats never reach DEPTH
  // while it arrives; reads completed so far free space.
  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input bit l);
    word_t w;
    int    occ;
    w = {l, k, d};
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    occ = commit_beats + cur.size() - (hs_cnt - int'(pend));
    if (in_drop) begin
      if (l) begin
        drops++;
        in_drop = 0;
      end
    end else if (occ == DEPTH) begin
      cur.delete();
      if (l) drops++;
      else in_drop = 1;
    end else begin
      cur.push_back(w);
      if (l) begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
        commit_beats += cur.size();
        commit_pkts++;
        cur.delete();
      end
    end
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      beat(base + DW'(i), 4'hF, i == len - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    step();
    step();
    exp_q.delete();
    cur.delete();
    commit_beats = 0;
    commit_pkts = 0;
    drops = 0;
    in_drop = 0;
    hs_cnt = 0;
    hs_last_cnt = 0;
    pend = 0;
    pend_last = 0;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_fill_level", 64'(fill_level), 64'(0));
    chk("rst_drop_cnt", 64'(drop_pkt_cnt), 64'(0));
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    s_tvalid = 1'b0;
    mode = 1;
    while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'(0));
    idle(3);
    chk({nm, "_idle_valid"}, 64'(m_tvalid), 64'(0));
  endtask

  initial begin
    do_reset();

    mode = 1;
    idle(1);
    beat(32'h1, 4'hF, 0);
    beat(32'h2, 4'hF, 0);
    beat(32'h3, 4'hF, 0);
    beat(32'h4, 4'hF, 1);
    chk("lat_edge_n", 64'(m_tvalid), 64'(0));
    chk("single_pkt_cnt", 64'(pkt_count), 64'(1));
    step();
    chk("lat_edge_n1", 64'(m_tvalid), 64'(0));
    step();
    chk("lat_edge_n2", 64'(m_tvalid), 64'(1));
    chk("single_first", 64'(m_tdata), 64'(1));
    drain("single");
    chk("single_pkt_end", 64'(pkt_count), 64'(0));

    mode = 0;
    idle(1);
    send_pkt(10, 32'h100);
    chk("fill_first", 64'(fill_level), 64'(10));
    send_pkt(8, 32'h200);
    chk("fill_after_drop", 64'(fill_level), 64'(10));
    chk("drop_one", 64'(drop_pkt_cnt), 64'(1));
    drain("fill");

    do_reset();
    mode = 1;
    idle(1);
    send_pkt(20, 32'h300);
    chk("oversize_drop", 64'(drop_pkt_cnt), 64'(1));
    chk("oversize_valid", 64'(m_tvalid), 64'(0));
    idle(4);
    chk("oversize_quiet", 64'(m_tvalid), 64'(0));
    send_pkt(3, 32'h400);
    drain("oversize");

    mode = 0;
    idle(1);
    beat(32'h500, 4'h0, 1);
    idle(3);
    chk("sim_valid", 64'(m_tvalid), 64'(1));
    mode = 1;
    idle(1);
    beat(32'h600, 4'h5, 1);
    chk("sim_pkt_count", 64'(pkt_count), 64'(1));
    chk("sim_fill", 64'(fill_level), 64'(1));
    drain("sim");

    mode = 2;
    for (int p = 0; p < 100; p++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        logic [KW-1:0] k;
        k = ($urandom_range(7, 0) == 0) ? '0 : KW'($urandom_range(15, 0));
        beat(DW'($urandom()), k, i == len - 1);
        if ($urandom_range(3, 0) == 0) idle(1);
      end
      idle($urandom_range(2, 0));
    end
    drain("random");

    mode = 1;
    idle(1);
    beat(32'hA1, 4'hF, 0);
    beat(32'hA2, 4'hF, 0);
    do_reset();
    beat(32'hA3, 4'hF, 0);
    beat(32'hA4, 4'hF, 0);
    beat(32'hA5, 4'hF, 1);
    chk("rst_mid_fill", 64'(fill_level), 64'(3));
    drain("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
